// File: rtl/instr_sequencer_if.sv
// Handshake bundle between the VR16 sequencer (master) and its instruction memory,
// ALU, data memory and register file (slave).
interface instr_sequencer_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] ir;
    logic        alu_start;
    logic        alu_done;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic        rf_we;
    logic        ins_done;
    logic [15:0] pc;
    logic        halted;
    logic        bus_error;

    modport master (
        output imem_req, imem_addr, ir, alu_start, dmem_req, dmem_we,
               rf_we, ins_done, pc, halted, bus_error,
        input  imem_ack, imem_rdata, alu_done, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr, ir, alu_start, dmem_req, dmem_we,
               rf_we, ins_done, pc, halted, bus_error,
        output imem_ack, imem_rdata, alu_done, dmem_ack
    );
endinterface

// File: rtl/instr_sequencer.sv
// VR16 multi-cycle control FSM: fetch, decode, execute, memory, writeback.
// Every output is a flop; nothing combinational reaches the outputs from inputs.
module instr_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input logic               clk,
    input logic               reset,
    instr_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        RST,
        FETCH,
        DECODE,
        EXECUTE,
        MEMORY,
        WRITEBACK,
        HALTED
    } state_e;

    localparam bit          WDOG_EN   = (TIMEOUT != 0);
    localparam logic [15:0] WDOG_LAST = WDOG_EN ? 16'(TIMEOUT - 1) : 16'h0000;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] wdog_q, wdog_d;
    logic        berr_q, berr_d;
    logic        imem_req_q, imem_req_d;
    logic        alu_start_q, alu_start_d;
    logic        dmem_req_q, dmem_req_d;
    logic        dmem_we_q, dmem_we_d;
    logic        rf_we_q, rf_we_d;
    logic        ins_done_q, ins_done_d;
    logic        halted_q, halted_d;
    logic        wdog_expired;

    function automatic logic is_alu(input logic [3:0] op);
        return (op != 4'h0) && !op[3];
    endfunction

    function automatic logic is_mem(input logic [3:0] op);
        return (op == 4'h8) || (op == 4'h9);
    endfunction

    // Counter value 0 is the first cycle in a wait state, so TIMEOUT-1 is the last allowed one.
    assign wdog_expired = WDOG_EN && (wdog_q == WDOG_LAST);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        berr_d  = berr_q;
        unique case (state_q)
            RST:     state_d = FETCH;
            FETCH: begin
                if (bus.imem_ack) begin
                    ir_d    = bus.imem_rdata;
                    state_d = DECODE;
                end else if (wdog_expired) begin
                    berr_d  = 1'b1;
                    state_d = HALTED;
                end
            end
            DECODE: begin
                if (is_alu(ir_q[15:12]))      state_d = EXECUTE;
                else if (is_mem(ir_q[15:12])) state_d = MEMORY;
                else                          state_d = WRITEBACK;
            end
            EXECUTE: begin
                if (bus.alu_done) begin
                    state_d = WRITEBACK;
                end else if (wdog_expired) begin
                    berr_d  = 1'b1;
                    state_d = HALTED;
                end
            end
            MEMORY: begin
                if (bus.dmem_ack) begin
                    state_d = WRITEBACK;
                end else if (wdog_expired) begin
                    berr_d  = 1'b1;
                    state_d = HALTED;
                end
            end
            WRITEBACK: begin
                pc_d    = (ir_q[15:12] == 4'hA) ? {4'h0, ir_q[11:0]} : pc_q + 16'd1;
                state_d = (ir_q[15:12] == 4'hF) ? HALTED : FETCH;
            end
            HALTED:  state_d = HALTED;
            default: state_d = RST;
        endcase

        if (state_d != state_q)  wdog_d = '0;
        else if (wdog_q != '1)   wdog_d = wdog_q + 16'd1;
        else                     wdog_d = wdog_q;

        // Outputs are precomputed from the next state so they land in the same cycle as it.
        imem_req_d  = (state_d == FETCH);
        alu_start_d = (state_d == EXECUTE) && (state_q != EXECUTE);
        dmem_req_d  = (state_d == MEMORY);
        dmem_we_d   = (state_d == MEMORY) && (ir_d[15:12] == 4'h9);
        rf_we_d     = (state_d == WRITEBACK) && (is_alu(ir_d[15:12]) || ir_d[15:12] == 4'h8);
        ins_done_d  = (state_d == WRITEBACK);
        halted_d    = (state_d == HALTED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RST;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            wdog_q      <= '0;
            berr_q      <= 1'b0;
            imem_req_q  <= 1'b0;
            alu_start_q <= 1'b0;
            dmem_req_q  <= 1'b0;
            dmem_we_q   <= 1'b0;
            rf_we_q     <= 1'b0;
            ins_done_q  <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            wdog_q      <= wdog_d;
            berr_q      <= berr_d;
            imem_req_q  <= imem_req_d;
            alu_start_q <= alu_start_d;
            dmem_req_q  <= dmem_req_d;
            dmem_we_q   <= dmem_we_d;
            rf_we_q     <= rf_we_d;
            ins_done_q  <= ins_done_d;
            halted_q    <= halted_d;
        end
    end

    assign bus.imem_req  = imem_req_q;
    assign bus.imem_addr = pc_q;
    assign bus.ir        = ir_q;
    assign bus.alu_start = alu_start_q;
    assign bus.dmem_req  = dmem_req_q;
    assign bus.dmem_we   = dmem_we_q;
    assign bus.rf_we     = rf_we_q;
    assign bus.ins_done  = ins_done_q;
    assign bus.pc        = pc_q;
    assign bus.halted    = halted_q;
    assign bus.bus_error = berr_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: a responder drives the handshakes with chosen wait counts and
// each retired instruction is compared against per-instruction expectations from the opcode rules.
module tb_instr_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        reset2;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] pc_m;

    always #5 clk = ~clk;

    instr_sequencer_if bus ();
    instr_sequencer_if bus2 ();

    instr_sequencer #(.RESET_PC(16'h0000), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    instr_sequencer #(.RESET_PC(16'hFFFF), .TIMEOUT(0)) dut2 (
        .clk(clk), .reset(reset2), .bus(bus2)
    );

    task automatic drive_idle();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        bus.alu_done   = 1'b0;
        bus.dmem_ack   = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        pc_m  = 16'h0000;
    endtask

    // Runs one instruction from its first FETCH cycle to its ins_done cycle.
    task automatic exec_instr(input logic [15:0] instr, input int fw, input int aw,
                              input int mw, input bit noise, input string tag);
        int          cyc, nreq, nalu, nmem, nwe, nrf, ndone, ecnt, mcnt, exp_cyc;
        bit          in_exec, finished, op_alu, op_ld, op_st, op_jmp;
        logic [3:0]  op;
        logic [15:0] faddr, ir_seen;
        op      = instr[15:12];
        op_alu  = (op >= 4'd1) && (op <= 4'd7);
        op_ld   = (op == 4'h8);
        op_st   = (op == 4'h9);
        op_jmp  = (op == 4'hA);
        exp_cyc = 3 + fw + (op_alu ? aw + 1 : 0) + ((op_ld || op_st) ? mw + 1 : 0);
        cyc = 0; nreq = 0; nalu = 0; nmem = 0; nwe = 0; nrf = 0; ndone = 0; ecnt = 0; mcnt = 0;
        in_exec = 1'b0; finished = 1'b0; faddr = 'x; ir_seen = 'x;
        @(negedge clk);
        while (!finished && cyc < 200) begin
            cyc++;
            if (bus.imem_req) begin
                if (nreq == 0) faddr = bus.imem_addr;
                nreq++;
            end
            if (bus.alu_start) begin nalu++; in_exec = 1'b1; end
            if (bus.dmem_req) nmem++;
            if (bus.dmem_we)  nwe++;
            if (bus.rf_we)    nrf++;
            if (bus.ins_done) begin ndone++; ir_seen = bus.ir; finished = 1'b1; end
            bus.imem_ack   = bus.imem_req ? (nreq == fw + 1) : (noise && $urandom_range(0, 1) == 1);
            bus.imem_rdata = bus.imem_req ? instr : 16'($urandom);
            if (in_exec) begin
                bus.alu_done = (ecnt == aw);
                if (ecnt == aw) in_exec = 1'b0;
                ecnt++;
            end else begin
                bus.alu_done = noise && $urandom_range(0, 1) == 1;
            end
            if (bus.dmem_req) begin
                bus.dmem_ack = (mcnt == mw);
                mcnt++;
            end else begin
                bus.dmem_ack = noise && $urandom_range(0, 1) == 1;
            end
            if (!finished) @(negedge clk);
        end
        checks++; if (ndone !== 1)   begin errors++; $display("FAIL %s done_count: got %0d expected 1", tag, ndone); end
        checks++; if (faddr !== pc_m) begin errors++; $display("FAIL %s fetch_addr: got %h expected %h", tag, faddr, pc_m); end
        checks++; if (nreq !== fw + 1) begin errors++; $display("FAIL %s imem_req_cycles: got %0d expected %0d", tag, nreq, fw + 1); end
        checks++; if (nalu !== (op_alu ? 1 : 0)) begin errors++; $display("FAIL %s alu_start_cycles: got %0d expected %0d", tag, nalu, op_alu ? 1 : 0); end
        checks++; if (nmem !== ((op_ld || op_st) ? mw + 1 : 0)) begin errors++; $display("FAIL %s dmem_req_cycles: got %0d expected %0d", tag, nmem, (op_ld || op_st) ? mw + 1 : 0); end
        checks++; if (nwe !== (op_st ? mw + 1 : 0)) begin errors++; $display("FAIL %s dmem_we_cycles: got %0d expected %0d", tag, nwe, op_st ? mw + 1 : 0); end
        checks++; if (nrf !== ((op_alu || op_ld) ? 1 : 0)) begin errors++; $display("FAIL %s rf_we_cycles: got %0d expected %0d", tag, nrf, (op_alu || op_ld) ? 1 : 0); end
        checks++; if (cyc !== exp_cyc) begin errors++; $display("FAIL %s latency: got %0d expected %0d", tag, cyc, exp_cyc); end
        checks++; if (ir_seen !== instr) begin errors++; $display("FAIL %s ir: got %h expected %h", tag, ir_seen, instr); end
        pc_m = op_jmp ? {4'h0, instr[11:0]} : pc_m + 16'd1;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        bus.imem_ack   = 1'b1;
        bus.alu_done   = 1'b1;
        bus.dmem_ack   = 1'b1;
        bus.imem_rdata = 16'hFFFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.imem_req, bus.alu_start, bus.dmem_req, bus.dmem_we, bus.rf_we,
             bus.ins_done, bus.halted, bus.bus_error} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 00000000", {bus.imem_req, bus.alu_start,
                     bus.dmem_req, bus.dmem_we, bus.rf_we, bus.ins_done, bus.halted, bus.bus_error});
        end
        checks++; if (bus.pc !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h expected 0000", bus.pc); end
        checks++; if (bus.ir !== 16'h0000) begin errors++; $display("FAIL reset_ir: got %h expected 0000", bus.ir); end
        drive_idle();
        reset = 1'b0;
        pc_m  = 16'h0000;
    endtask

    task automatic test_nop_stream();
        for (int i = 0; i < 6; i++) exec_instr(16'h0000, 0, 0, 0, 1'b0, "nop_stream");
    endtask

    task automatic test_alu();
        exec_instr(16'h1234, 0, 2, 0, 1'b0, "alu_delayed");
    endtask

    task automatic test_load_store();
        exec_instr(16'h8012, 0, 0, 1, 1'b0, "load");
        exec_instr(16'h9034, 0, 0, 1, 1'b0, "store");
    endtask

    task automatic test_jmp();
        exec_instr(16'hA123, 0, 0, 0, 1'b0, "jmp");
        exec_instr(16'h0000, 0, 0, 0, 1'b0, "after_jmp");
    endtask

    task automatic test_last_cycle_ack();
        exec_instr(16'h7FFF, 15, 15, 0, 1'b1, "alu_last_cycle");
        exec_instr(16'h9ABC, 15, 0, 15, 1'b1, "store_last_cycle");
        exec_instr(16'hC555, 2, 0, 0, 1'b1, "reserved");
    endtask

    task automatic test_random();
        logic [15:0] instr;
        for (int i = 0; i < 30; i++) begin
            instr = 16'($urandom);
            instr[15:12] = 4'($urandom_range(0, 14));
            exec_instr(instr, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), 1'b1, "random");
        end
    endtask

    task automatic test_halt();
        int nbad;
        exec_instr(16'hF000, 0, 0, 0, 1'b0, "halt");
        nbad = 0;
        repeat (20) begin
            @(negedge clk);
            bus.imem_ack = 1'($urandom);
            if (!bus.halted || bus.imem_req || bus.ins_done || bus.alu_start || bus.dmem_req || bus.rf_we)
                nbad++;
        end
        checks++; if (nbad !== 0) begin errors++; $display("FAIL halted_quiet: got %0d bad cycles expected 0", nbad); end
        checks++; if (bus.pc !== pc_m) begin errors++; $display("FAIL halt_pc: got %h expected %h", bus.pc, pc_m); end
        apply_reset();
        checks++; if (bus.pc !== 16'h0000) begin errors++; $display("FAIL halt_reset_pc: got %h expected 0000", bus.pc); end
        checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL halt_reset_halted: got %b expected 0", bus.halted); end
    endtask

    task automatic test_timeout();
        int cyc, nreq, ndone;
        cyc = 0; nreq = 0; ndone = 0;
        drive_idle();
        while (!bus.halted && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.imem_req) nreq++;
            if (bus.ins_done) ndone++;
        end
        checks++; if (nreq !== 16) begin errors++; $display("FAIL timeout_fetch_cycles: got %0d expected 16", nreq); end
        checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL timeout_halted: got %b expected 1", bus.halted); end
        checks++; if (ndone !== 0) begin errors++; $display("FAIL timeout_ins_done: got %0d expected 0", ndone); end
        repeat (5) @(negedge clk);
        checks++; if (bus.bus_error !== 1'b1) begin errors++; $display("FAIL timeout_bus_error: got %b expected 1", bus.bus_error); end
        apply_reset();
        checks++; if (bus.bus_error !== 1'b0) begin errors++; $display("FAIL timeout_reset_clear: got %b expected 0", bus.bus_error); end
    endtask

    task automatic test_reset_mid_memory();
        int seen, cyc;
        seen = 0; cyc = 0;
        drive_idle();
        while (seen < 2 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            bus.imem_ack   = bus.imem_req;
            bus.imem_rdata = 16'h8000;
            if (bus.dmem_req) seen++;
        end
        checks++; if (seen !== 2) begin errors++; $display("FAIL midmem_reach: got %0d dmem_req cycles expected 2", seen); end
        reset = 1'b1;
        drive_idle();
        @(negedge clk);
        checks++;
        if ({bus.imem_req, bus.dmem_req, bus.dmem_we, bus.rf_we, bus.ins_done, bus.halted} !== 6'h00) begin
            errors++;
            $display("FAIL midmem_reset_outputs: got %b expected 000000",
                     {bus.imem_req, bus.dmem_req, bus.dmem_we, bus.rf_we, bus.ins_done, bus.halted});
        end
        reset = 1'b0;
        pc_m  = 16'h0000;
        exec_instr(16'h0000, 0, 0, 0, 1'b0, "restart");
    endtask

    task automatic test_wrap_no_watchdog();
        int cyc;
        bit got_done;
        bus2.imem_ack = 1'b0;
        @(negedge clk);
        reset2 = 1'b0;
        repeat (40) @(negedge clk);
        checks++; if (bus2.imem_req !== 1'b1) begin errors++; $display("FAIL nowdog_still_fetching: got %b expected 1", bus2.imem_req); end
        checks++; if ({bus2.halted, bus2.bus_error} !== 2'b00) begin errors++; $display("FAIL nowdog_no_error: got %b expected 00", {bus2.halted, bus2.bus_error}); end
        checks++; if (bus2.imem_addr !== 16'hFFFF) begin errors++; $display("FAIL wrap_fetch_addr: got %h expected ffff", bus2.imem_addr); end
        bus2.imem_ack = 1'b1;
        cyc = 0; got_done = 1'b0;
        while (!got_done && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (bus2.ins_done) got_done = 1'b1;
        end
        checks++; if (!got_done) begin errors++; $display("FAIL wrap_done: got 0 expected 1"); end
        @(negedge clk);
        checks++; if (bus2.pc !== 16'h0000) begin errors++; $display("FAIL wrap_pc: got %h expected 0000", bus2.pc); end
        checks++; if (bus2.imem_addr !== 16'h0000 || bus2.imem_req !== 1'b1) begin errors++; $display("FAIL wrap_refetch: got %h/%b expected 0000/1", bus2.imem_addr, bus2.imem_req); end
    endtask

    initial begin
        reset  = 1'b1;
        reset2 = 1'b1;
        drive_idle();
        bus2.imem_ack   = 1'b0;
        bus2.imem_rdata = 16'h0000;
        bus2.alu_done   = 1'b0;
        bus2.dmem_ack   = 1'b0;
        test_reset();
        test_nop_stream();
        test_alu();
        test_load_store();
        test_jmp();
        test_last_cycle_ack();
        test_random();
        test_halt();
        test_timeout();
        test_reset_mid_memory();
        test_wrap_no_watchdog();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
